cprv_fetch_unit: RTL
====================

Name: cprv_fetch_unit

Overview:
- Initiator side of the instruction-memory request/response protocol. The instruction ROM is the responder.
- Generates sequential fetch addresses and issues them on the address channel.
- Accepts in-order instruction responses on the data channel and buffers them with their PCs.
- Presents {pc, instr} to decode through a valid/ready interface; handles branch redirects, including discarding in-flight responses.

Parameters:
- ADDR_WIDTH, 32, width of the fetch address and the PC.
- INSTR_WIDTH, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.
- DEPTH, 2, instruction buffer entries; also the maximum number of in-flight requests. Power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect_i  in  1  flush and restart fetch at redirect_pc_i.
- redirect_pc_i  in  ADDR_WIDTH  new PC; bits [1:0] ignored (treated as 0).
- valid_imem  out  1  request valid, address channel.
- ready_imem  in  1  responder accepts the request.
- instr_addr_imem  out  ADDR_WIDTH  fetch address.
- valid_if  in  1  response valid, data channel.
- ready_if  out  1  fetch unit accepts the response.
- instr_data_imem  in  INSTR_WIDTH  returned instruction.
- valid_o  out  1  instruction valid to decode.
- ready_i  in  1  decode accepts the instruction.
- instr_o  out  INSTR_WIDTH  instruction to decode.
- pc_o  out  ADDR_WIDTH  PC of instr_o.

Behaviour:
- Reset (asynchronous assert, synchronous release): fetch PC = RESET_PC; outstanding = 0; drop_cnt = 0; buffer empty.
  - Outputs in reset: valid_imem=0, instr_addr_imem=RESET_PC, ready_if=1, valid_o=0, instr_o=0, pc_o=0.
  - valid_imem may first assert in the first cycle after rst_n deasserts.
- Request channel:
  - valid_imem = !redirect_i && (outstanding + count < DEPTH), where count is the number of buffered entries.
  - instr_addr_imem = fetch PC. Once valid_imem is high, the address is held stable until accepted or a redirect occurs.
  - On a request handshake (valid_imem && ready_imem): PC += 4 (modulo 2^ADDR_WIDTH, wraps silently); the issued PC is pushed into the internal pc-tag FIFO; outstanding increments.
- Response channel:
  - ready_if is held at 1. The credit rule guarantees buffer space, so the fetch unit never stalls the responder.
  - On valid_if, outstanding decrements.
  - If drop_cnt > 0: the response is discarded and drop_cnt decrements.
  - Otherwise {pc-tag head, instr_data_imem} is written to the instruction buffer. The next cycle valid_o=1 (registered buffer, no bypass).
- Minimum latency: request accepted in cycle N, response in cycle N+1, valid_o in cycle N+2.
- Decode side:
  - Standard valid/ready. instr_o and pc_o are the buffer head and hold stable while valid_o && !ready_i.
  - Pop on valid_o && ready_i.
  - Push and pop in the same cycle are allowed: count is unchanged.
- Redirect (single-cycle pulse, takes priority over everything else in that cycle):
  - Buffer flushed; valid_o=0 in the next cycle.
  - PC ← {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00}.
  - drop_cnt ← outstanding − (1 if valid_if this cycle) + (drop_cnt already pending handled identically, i.e. drop_cnt ← total in-flight after this cycle).
  - Any response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
  - A pop in the redirect cycle is ignored, since the buffer is flushed.
  - Back-to-back redirects: the last one wins; all older in-flight responses are dropped.
- Invariants (bench asserts these):
  - outstanding ≤ DEPTH.
  - count ≤ DEPTH.
  - drop_cnt ≤ outstanding.
  - valid_if never seen while outstanding = 0.

Test Plan:
- Reset release, RESET_PC=0, responder always ready with 1-cycle response latency, ready_i=1 → addresses 0,4,8,…; decode sees pc_o=0,4,8 with matching instr, first valid_o 2 cycles after the first request accept.
- ready_i=0 for 10 cycles, DEPTH=2 → exactly 2 requests issued, then valid_imem=0; instr_o/pc_o hold =0x0; after ready_i=1, fetch resumes at 0x8 with no loss or duplication.
- ready_imem=0 for 5 cycles with valid_imem=1 → instr_addr_imem stable; PC does not advance.
- Redirect to 0x103 with 2 requests outstanding, responder 3-cycle latency → both stale responses dropped; next request addr 0x100; first decode pc_o=0x100.
- Redirect in the same cycle as valid_if and ready_i=1 → response dropped, no request issued that cycle, valid_o=0 next cycle, no pop counted.
- PC at 0xFFFFFFFC, sequential fetch → next address 0x0; rst_n asserted mid-stream → all outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/cprv_fetch_unit.sv
// Instruction fetch unit: issues sequential fetch requests to the instruction
// ROM, tags in-order responses with their PCs, buffers them and hands
// {pc, instr} to decode over valid/ready. Redirects flush the buffer and
// discard every response still in flight at that moment.
module cprv_fetch_unit #(
    parameter int unsigned              ADDR_WIDTH  = 32,
    parameter int unsigned              INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC    = '0,
    parameter int unsigned              DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    output logic                   valid_imem,
    input  logic                   ready_imem,
    output logic [ADDR_WIDTH-1:0]  instr_addr_imem,
    input  logic                   valid_if,
    output logic                   ready_if,
    input  logic [INSTR_WIDTH-1:0] instr_data_imem,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  pc_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Fetch PC and the one-cycle gate that keeps requests quiet during reset.
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic                   run_q;

    // Credit bookkeeping: requests in flight, of which drop_cnt are stale.
    logic [CW-1:0]          outstanding_q;
    logic [CW-1:0]          drop_cnt_q;

    // PC tags of issued requests, consumed in order by responses.
    logic [ADDR_WIDTH-1:0]  tag_mem [DEPTH];
    logic [PW-1:0]          tag_wr_q;
    logic [PW-1:0]          tag_rd_q;

    // Instruction buffer presented to decode.
    logic [ADDR_WIDTH-1:0]  buf_pc    [DEPTH];
    logic [INSTR_WIDTH-1:0] buf_instr [DEPTH];
    logic [PW-1:0]          buf_wr_q;
    logic [PW-1:0]          buf_rd_q;
    logic [CW-1:0]          count_q;

    logic                   credit_ok;
    logic                   req_fire;
    logic                   rsp_keep;
    logic                   buf_push;
    logic                   buf_pop;
    logic                   unused_rpc_lsbs;

    assign unused_rpc_lsbs = &{1'b0, redirect_pc_i[1:0]};

    // Request credit, handshake qualifiers and the decode-side view.
    always_comb begin
        credit_ok       = ((CW+1)'(outstanding_q) + (CW+1)'(count_q)) < (CW+1)'(DEPTH);
        valid_imem      = run_q && !redirect_i && credit_ok;
        instr_addr_imem = pc_q;
        ready_if        = 1'b1;
        req_fire        = valid_imem && ready_imem;
        rsp_keep        = valid_if && (drop_cnt_q == '0);
        valid_o         = (count_q != '0);
        buf_push        = rsp_keep && !redirect_i;
        buf_pop         = valid_o && ready_i && !redirect_i;
        instr_o         = buf_instr[buf_rd_q];
        pc_o            = buf_pc[buf_rd_q];
    end

    // Request gate opens in the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Fetch PC: redirect target (word aligned) or advance on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (redirect_i) begin
            pc_q <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (req_fire) begin
            pc_q <= pc_q + ADDR_WIDTH'(4);
        end
    end

    // In-flight counter and stale-response counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_q + CW'(req_fire) - CW'(valid_if);
            if (redirect_i) begin
                // Everything still in flight after this cycle is stale,
                // including responses already marked for dropping.
                drop_cnt_q <= outstanding_q - CW'(valid_if);
            end else if (valid_if && (drop_cnt_q != '0)) begin
                drop_cnt_q <= drop_cnt_q - CW'(1);
            end
        end
    end

    // PC-tag FIFO: one entry per issued request, popped by every response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            if (req_fire) begin
                tag_mem[tag_wr_q] <= pc_q;
                tag_wr_q          <= tag_wr_q + PW'(1);
            end
            if (valid_if) begin
                tag_rd_q <= tag_rd_q + PW'(1);
            end
        end
    end

    // Instruction buffer: push kept responses, pop on decode handshake, flush on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_wr_q <= '0;
            buf_rd_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_pc[i]    <= '0;
                buf_instr[i] <= '0;
            end
        end else if (redirect_i) begin
            buf_rd_q <= buf_wr_q;
            count_q  <= '0;
        end else begin
            if (buf_push) begin
                buf_pc[buf_wr_q]    <= tag_mem[tag_rd_q];
                buf_instr[buf_wr_q] <= instr_data_imem;
                buf_wr_q            <= buf_wr_q + PW'(1);
            end
            if (buf_pop) begin
                buf_rd_q <= buf_rd_q + PW'(1);
            end
            count_q <= count_q + CW'(buf_push) - CW'(buf_pop);
        end
    end

endmodule
